// File: rtl/ifft2_stream_if.sv
// ifft2_stream_if
// Stream bundle for the ifft2_stream inverse butterfly.
//   in_valid / in_ready / X0 / X1  : input pair handshake, packed Q8.8 complex
//                                    {re[31:16], im[15:0]}
//   out_valid / out_ready / x0 / x1: output pair handshake, packed Q16.16 complex
//                                    {re[63:32], im[31:0]}
//   out_last / frame_cnt           : framing side-band qualifying the output pair
// The slave modport is the butterfly's view; the master modport is the view of
// whoever feeds the spectrum in and drains the time samples out.
interface ifft2_stream_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      X0;
  logic [31:0]      X1;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      x0;
  logic [63:0]      x1;
  logic             out_last;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, X0, X1, out_ready,
    input  in_ready, out_valid, x0, x1, out_last, frame_cnt
  );

  modport slave (
    input  in_valid, X0, X1, out_ready,
    output in_ready, out_valid, x0, x1, out_last, frame_cnt
  );
endinterface

// File: rtl/ifft2_stream.sv
// ifft2_stream
// Two-point inverse butterfly on a valid/ready stream.
//   x0 = (X0 + X1) / 2 , x1 = (X0 - X1) / 2
// Inputs are packed Q8.8 complex values, outputs packed Q16.16 complex values.
// Two register stages: s1 holds the 17-bit sums/differences, s2 holds the
// widened results and is the output register. Each stage only advances when
// the stage after it can take its contents, so at most two pairs are held
// under backpressure and nothing is dropped or repeated.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, discards everything in flight
//   bus  : ifft2_stream_if slave modport (handshakes, data, framing)
// Parameters:
//   FRAME_LEN : output pairs per frame (1 .. 2**CNT_W)
//   CNT_W     : width of frame_cnt
module ifft2_stream #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 4
) (
  input logic           clk,
  input logic           rst,
  ifft2_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic               s1_valid;
  logic signed [16:0] sr;
  logic signed [16:0] si;
  logic signed [16:0] dr;
  logic signed [16:0] di;

  logic               s2_valid;
  logic [63:0]        s2_x0;
  logic [63:0]        s2_x1;

  logic [CNT_W-1:0]   cnt;

  logic               s2_adv;
  logic               s1_adv;
  logic               accept;
  logic               consume;
  logic               at_last;

  // Sign-extend a Q8.8 field by one bit so the add/subtract cannot overflow.
  function automatic logic signed [16:0] sext17(input logic [15:0] v);
    return {v[15], v};
  endfunction

  // Q8.8 -> Q16.16 is << 8, halving is >> 1, so a 17-bit sum becomes
  // sign_extend_32(v) << 7. All 17 bits survive, so the result is exact.
  function automatic logic [31:0] widen(input logic signed [16:0] v);
    return {{8{v[16]}}, v, 7'b0};
  endfunction

  // Advance rules: a stage may move when the stage downstream is empty or
  // emptying this cycle. in_ready only looks at pipeline state and out_ready,
  // never at in_valid.
  always_comb begin
    s2_adv  = !s2_valid || bus.out_ready;
    s1_adv  = !s1_valid || s2_adv;
    accept  = bus.in_valid && s1_adv;
    consume = s2_valid && bus.out_ready;
    at_last = (cnt == LAST_IDX);
  end

  // Stage 1: register the raw sums and differences of the incoming pair.
  // When s1 moves on without a new pair behind it, it simply goes empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      sr       <= '0;
      si       <= '0;
      dr       <= '0;
      di       <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        sr <= sext17(bus.X0[31:16]) + sext17(bus.X1[31:16]);
        si <= sext17(bus.X0[15:0])  + sext17(bus.X1[15:0]);
        dr <= sext17(bus.X0[31:16]) - sext17(bus.X1[31:16]);
        di <= sext17(bus.X0[15:0])  - sext17(bus.X1[15:0]);
      end
    end
  end

  // Stage 2: output register. Data only changes when s2 advances with s1
  // full, so x0/x1 stay frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x0    <= '0;
      s2_x1    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x0 <= {widen(sr), widen(si)};
        s2_x1 <= {widen(dr), widen(di)};
      end
    end
  end

  // Frame counter: counts consumed output pairs and wraps after the pair
  // flagged out_last is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (consume) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.x0        = s2_x0;
  assign bus.x1        = s2_x1;
  assign bus.out_last  = s2_valid && at_last;
  assign bus.frame_cnt = cnt;

endmodule

// File: tb/tb_ifft2_stream.sv
// tb_ifft2_stream
// Self-checking bench for ifft2_stream. A negedge monitor keeps a queue of
// expected output pairs (computed with integer arithmetic from the accepted
// inputs) plus a frame position, and checks every consumed pair, framing and
// stall stability. Directed table vectors, reset, framing and backpressure
// sequences run first, then a randomized run with random backpressure.
module tb_ifft2_stream;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifft2_stream_if #(.CNT_W(CNT_W)) bus ();

  ifft2_stream #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t        vecs[5];

  int          vectors      = 0;
  int          miscompares  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_pair;
  int          model_cnt    = 0;
  bit          held         = 1'b0;
  logic [63:0] prev_x0;
  logic [63:0] prev_x1;
  logic        prev_last;
  int          run_len      = 0;
  int          max_run      = 0;
  int          lasts_seen   = 0;
  int          consumed     = 0;
  int          stall_cycles = 0;
  int          ready_mode   = 0;
  logic        ready_level  = 1'b1;
  int          phase        = 0;

  // Reference: halve the complex sum/difference and express it in Q16.16.
  // In integer units, (a+b)/2 * 2^16 / 2^8 = (a+b) * 128.
  function automatic logic [127:0] model(input logic [31:0] a, input logic [31:0] b);
    int ar, ai, br, bi;
    logic [31:0] x0r, x0i, x1r, x1i;
    ar  = int'($signed(a[31:16]));
    ai  = int'($signed(a[15:0]));
    br  = int'($signed(b[31:16]));
    bi  = int'($signed(b[15:0]));
    x0r = 32'((ar + br) * 128);
    x0i = 32'((ai + bi) * 128);
    x1r = 32'((ar - br) * 128);
    x1i = 32'((ai - bi) * 128);
    return {x0r, x0i, x1r, x1i};
  endfunction

  function automatic logic [15:0] pick16();
    logic [31:0] r;
    int sel;
    sel = $urandom_range(0, 7);
    r   = $urandom();
    if (sel == 0) return 16'h7FFF;
    if (sel == 1) return 16'h8000;
    return r[15:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present a pair and hold it until the block takes it; returns #1 after
  // the accepting edge.
  task automatic apply_pair(input logic [31:0] a, input logic [31:0] b);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.X0       = a;
    bus.X1       = b;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (!acc) stall_cycles++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_output("accept_timeout", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  // Downstream ready driver: fixed level, 1,0,0,1 pattern, or random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1: begin
          bus.out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
          phase++;
        end
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = ready_level;
      endcase
    end
  end

  // Reset drops everything the model was expecting.
  always @(posedge rst) begin
    exp_q.delete();
    model_cnt = 0;
    held      = 1'b0;
    run_len   = 0;
  end

  // Scoreboard monitor: looks at the state that the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        check_output("stall_valid", 64'(bus.out_valid), 64'd1);
        check_output("stall_x0", bus.x0, prev_x0);
        check_output("stall_x1", bus.x1, prev_x1);
        check_output("stall_last", 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid) begin
        check_output("out_last", 64'(bus.out_last), 64'(model_cnt == FRAME_LEN - 1));
        check_output("frame_cnt", 64'(bus.frame_cnt), 64'(model_cnt));
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_out", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_pair = exp_q.pop_front();
          check_output("x0", bus.x0, exp_pair[127:64]);
          check_output("x1", bus.x1, exp_pair[63:0]);
        end
        consumed++;
        if (bus.out_last) lasts_seen++;
        model_cnt = (model_cnt == FRAME_LEN - 1) ? 0 : model_cnt + 1;
      end
      held      = bus.out_valid && !bus.out_ready;
      prev_x0   = bus.x0;
      prev_x1   = bus.x1;
      prev_last = bus.out_last;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.X0, bus.X1));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int gap;

    vecs[0] = '{"one_plus_one", 32'h0100_0000, 32'h0100_0000,
                64'h00010000_00000000, 64'h00000000_00000000};
    vecs[1] = '{"extremes_a",   32'h7FFF_8000, 32'h8000_8000,
                64'hFFFFFF80_FF800000, 64'h007FFF80_00000000};
    vecs[2] = '{"extremes_b",   32'h8000_7FFF, 32'h7FFF_8000,
                64'hFFFFFF80_FFFFFF80, 64'hFF800080_007FFF80};
    vecs[3] = '{"mixed_sign",   32'h0080_FF00, 32'h0040_0100,
                64'h00006000_00000000, 64'h00002000_FFFF0000};
    vecs[4] = '{"zeros",        32'h0000_0000, 32'h0000_0000,
                64'h00000000_00000000, 64'h00000000_00000000};

    bus.in_valid = 1'b0;
    bus.X0       = '0;
    bus.X1       = '0;

    // Reset state.
    #1;
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_x0", bus.x0, 64'd0);
    check_output("rst_x1", bus.x1, 64'd0);
    check_output("rst_out_last", 64'(bus.out_last), 64'd0);
    check_output("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors: the pair shows up after the second register stage.
    for (int i = 0; i < 5; i++) begin
      apply_pair(vecs[i].a, vecs[i].b);
      check_output({vecs[i].name, "_early"}, 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check_output({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check_output({vecs[i].name, "_x0"}, bus.x0, vecs[i].e0);
      check_output({vecs[i].name, "_x1"}, bus.x1, vecs[i].e1);
      @(posedge clk);
      #1;
    end

    // Reset with both stages full and the consumer stalled.
    ready_level = 1'b0;
    apply_pair(32'h0123_4567, 32'h0011_0022);
    apply_pair(32'h0200_0300, 32'hFF00_0100);
    check_output("full_in_ready", 64'(bus.in_ready), 64'd0);
    check_output("full_out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("midrst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    check_output("midrst_x0", bus.x0, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_level = 1'b1;
    check_output("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_output("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end

    // One full frame back to back.
    stall_cycles = 0;
    max_run      = 0;
    lasts_seen   = 0;
    consumed     = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      ra = $urandom();
      rb = $urandom();
      apply_pair(ra, rb);
    end
    wait_empty();
    check_output("frame_run", 64'(max_run), 64'(FRAME_LEN));
    check_output("frame_lasts", 64'(lasts_seen), 64'd1);
    check_output("frame_wrap", 64'(bus.frame_cnt), 64'd0);
    check_output("frame_stalls", 64'(stall_cycles), 64'd0);
    check_output("frame_count", 64'(consumed), 64'(FRAME_LEN));

    // Backpressure with out_ready cycling 1,0,0,1.
    phase        = 0;
    stall_cycles = 0;
    consumed     = 0;
    ready_mode   = 1;
    for (int i = 0; i < 5; i++) begin
      ra = {pick16(), pick16()};
      rb = {pick16(), pick16()};
      apply_pair(ra, rb);
    end
    ready_mode  = 0;
    ready_level = 1'b1;
    wait_empty();
    check_output("bp_count", 64'(consumed), 64'd5);
    check_output("bp_in_ready_drop", 64'(stall_cycles > 0), 64'd1);

    // Random pairs with random gaps and random backpressure.
    consumed   = 0;
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      ra = {pick16(), pick16()};
      rb = {pick16(), pick16()};
      apply_pair(ra, rb);
    end
    ready_mode  = 0;
    ready_level = 1'b1;
    wait_empty();
    check_output("rand_count", 64'(consumed), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
